// File: rtl/gb_host_pkg.sv
// Shared types and constants for the GB host stream engine.
package gb_host_pkg;

  typedef enum logic [1:0] {IDLE, TRANS, DONE} state_e;

  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

  localparam int GB_CMD_W = 3;
  typedef logic [GB_CMD_W-1:0] cmd_t;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/gb_host_prefetch_fifo.sv
// Two-entry FIFO holding SRAM read data ahead of the host->chip beat handshake.
module gb_host_prefetch_fifo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/gb_host_stream_engine.sv
// Host-side GB engine: grants a command, then streams its table-defined beats
// between the chip port and a single-port SRAM using per-command wrapping pointers.
//   state | meaning
//   IDLE  | waiting for a command; ptr_clr honoured here
//   TRANS | moving beats (read: SRAM->rd_*, write: wr_*->SRAM)
//   DONE  | one-cycle completion pulse
module gb_host_stream_engine
  import gb_host_pkg::*;
#(
  parameter int          DATA_W    = 128,
  parameter int          CMD_W     = GB_CMD_W,
  parameter int          NUM_CMD   = 2**CMD_W,
  parameter int          ADDR_W    = 12,
  parameter int          LEN_W     = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_val_i,
  output logic                      cfg_rdy_o,
  input  logic [CMD_W:0]            cfg_info_i,
  output logic                      rd_val_o,
  input  logic                      rd_rdy_i,
  output logic [DATA_W-1:0]         rd_data_o,
  input  logic                      wr_val_i,
  output logic                      wr_rdy_o,
  input  logic [DATA_W-1:0]         wr_data_i,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  input  logic [NUM_CMD*LEN_W-1:0]  tbl_len_i,
  input  logic [NUM_CMD*ADDR_W-1:0] tbl_base_i,
  input  logic [NUM_CMD*ADDR_W-1:0] tbl_size_i,
  input  logic [3:0]                thr_thresh_i,
  input  logic                      ptr_clr_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CMD_W-1:0]          cur_cmd_o
);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic              stall;
  logic              cfg_rdy_q, cfg_rdy_d;
  logic [CMD_W-1:0]  cmd_q;
  logic              dir_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beat_q, issued_q;
  logic              inflight_q, rd_hold_q, init_q;
  logic [ADDR_W-1:0] ptr_q [NUM_CMD];

  logic [LEN_W-1:0]  len_arr  [NUM_CMD];
  logic [ADDR_W-1:0] base_arr [NUM_CMD];
  logic [ADDR_W-1:0] size_arr [NUM_CMD];

  for (genvar k = 0; k < NUM_CMD; k++) begin : g_tbl
    assign len_arr[k]  = tbl_len_i[k*LEN_W +: LEN_W];
    assign base_arr[k] = tbl_base_i[k*ADDR_W +: ADDR_W];
    assign size_arr[k] = tbl_size_i[k*ADDR_W +: ADDR_W];
  end

  logic [ADDR_W-1:0] cur_ptr, cur_base, nxt_ptr;
  logic [ADDR_W:0]   ptr_inc, region_end;

  assign cur_ptr    = ptr_q[cmd_q];
  assign cur_base   = base_arr[cmd_q];
  assign ptr_inc    = {1'b0, cur_ptr} + (ADDR_W+1)'(1);
  assign region_end = {1'b0, cur_base} + {1'b0, size_arr[cmd_q]};
  assign nxt_ptr    = (ptr_inc == region_end) ? cur_base : ptr_inc[ADDR_W-1:0];

  logic [1:0]        fifo_cnt, occ;
  logic [DATA_W-1:0] fifo_data;
  logic              cfg_hs, rd_mode, wr_mode, rd_hs, wr_hs, issue, beat_hs, last_beat;

  assign stall   = lfsr_q[3:0] < thr_thresh_i;
  assign cfg_hs  = (state_q == IDLE) && cfg_rdy_q && cfg_val_i;
  assign rd_mode = (state_q == TRANS) && (dir_q == DIR_RD);
  assign wr_mode = (state_q == TRANS) && (dir_q == DIR_WR);

  // A presented beat is held through later stalls until the chip takes it
  assign rd_val_o  = rd_mode && (fifo_cnt != 2'd0) && (!stall || rd_hold_q);
  assign rd_data_o = rd_val_o ? fifo_data : '0;
  assign rd_hs     = rd_val_o && rd_rdy_i;
  assign wr_rdy_o  = wr_mode && !stall;
  assign wr_hs     = wr_rdy_o && wr_val_i;

  // Occupancy counts this cycle's pop so back-to-back beats need no bubble
  assign occ       = fifo_cnt - {1'b0, rd_hs} + {1'b0, inflight_q};
  assign issue     = rd_mode && (issued_q <= {1'b0, len_q}) && (occ < 2'd2);
  assign beat_hs   = rd_hs || wr_hs;
  assign last_beat = beat_hs && (beat_q == {1'b0, len_q});

  assign mem_en_o    = issue || wr_hs;
  assign mem_we_o    = wr_hs;
  assign mem_addr_o  = mem_en_o ? cur_ptr : '0;
  assign mem_wdata_o = wr_hs ? wr_data_i : '0;

  assign cfg_rdy_o = cfg_rdy_q;
  assign busy_o    = state_q != IDLE;
  assign done_o    = state_q == DONE;
  assign cur_cmd_o = cmd_q;

  gb_host_prefetch_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (mem_rdata_i),
    .pop_i   (rd_hs),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    cfg_rdy_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_hs) state_d = TRANS;
        else        cfg_rdy_d = cfg_rdy_q || !stall;
      end
      TRANS:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      cfg_rdy_q  <= 1'b0;
      cmd_q      <= '0;
      dir_q      <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      rd_hold_q  <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      cfg_rdy_q  <= cfg_rdy_d;
      inflight_q <= issue;
      rd_hold_q  <= rd_val_o && !rd_rdy_i;
      init_q     <= 1'b0;
      if (cfg_hs) begin
        cmd_q    <= cfg_info_i[CMD_W:1];
        dir_q    <= cfg_info_i[0];
        len_q    <= len_arr[cfg_info_i[CMD_W:1]];
        beat_q   <= '0;
        issued_q <= '0;
      end else begin
        if (beat_hs) beat_q   <= beat_q + (LEN_W+1)'(1);
        if (issue)   issued_q <= issued_q + (LEN_W+1)'(1);
      end
    end
  end

  // Pointers reload from the table right after reset and on an IDLE clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CMD; k++) ptr_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CMD; k++) begin
        if (init_q || ((state_q == IDLE) && ptr_clr_i))
          ptr_q[k] <= base_arr[k];
        else if ((issue || wr_hs) && (cmd_q == CMD_W'(k)))
          ptr_q[k] <= nxt_ptr;
      end
    end
  end

endmodule

// File: tb/tb_gb_host_stream_engine.sv
// Directed self-checking bench for gb_host_stream_engine with a behavioural SRAM.
module tb_gb_host_stream_engine;
  import gb_host_pkg::*;

  localparam int DATA_W = 128, CMD_W = 3, NUM_CMD = 8, ADDR_W = 12, LEN_W = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_val = 1'b0, cfg_rdy;
  logic [CMD_W:0] cfg_info = '0;
  logic rd_val, rd_rdy = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic wr_val = 1'b0, wr_rdy;
  logic [DATA_W-1:0] wr_data = '0;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata = '0;
  logic [NUM_CMD*LEN_W-1:0] tbl_len;
  logic [NUM_CMD*ADDR_W-1:0] tbl_base, tbl_size;
  logic [3:0] thr = 4'd0;
  logic ptr_clr = 1'b0;
  logic busy, done;
  logic [CMD_W-1:0] cur_cmd;

  logic [LEN_W-1:0]  t_len  [NUM_CMD];
  logic [ADDR_W-1:0] t_base [NUM_CMD];
  logic [ADDR_W-1:0] t_size [NUM_CMD];
  for (genvar k = 0; k < NUM_CMD; k++) begin : g_tbl
    assign tbl_len[k*LEN_W +: LEN_W]   = t_len[k];
    assign tbl_base[k*ADDR_W +: ADDR_W] = t_base[k];
    assign tbl_size[k*ADDR_W +: ADDR_W] = t_size[k];
  end

  always #5 clk = ~clk;

  gb_host_stream_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_val_i(cfg_val), .cfg_rdy_o(cfg_rdy), .cfg_info_i(cfg_info),
    .rd_val_o(rd_val), .rd_rdy_i(rd_rdy), .rd_data_o(rd_data),
    .wr_val_i(wr_val), .wr_rdy_o(wr_rdy), .wr_data_i(wr_data),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .tbl_len_i(tbl_len), .tbl_base_i(tbl_base), .tbl_size_i(tbl_size),
    .thr_thresh_i(thr), .ptr_clr_i(ptr_clr),
    .busy_o(busy), .done_o(done), .cur_cmd_o(cur_cmd)
  );

  logic [DATA_W-1:0] sram [4096];
  int checks = 0, errors = 0;
  int cyc = 0, iss_cnt = 0, pop_cnt = 0;
  logic [ADDR_W-1:0] ma_addr [$];
  logic              ma_we   [$];
  logic [DATA_W-1:0] ma_data [$];
  logic [DATA_W-1:0] rd_log  [$];
  int                rd_cyc  [$];
  logic [DATA_W-1:0] wpat;

  always @(posedge clk) begin
    cyc++;
    if (mem_en) begin
      ma_addr.push_back(mem_addr);
      ma_we.push_back(mem_we);
      ma_data.push_back(mem_wdata);
      if (mem_we) sram[mem_addr] = mem_wdata;
      else begin
        mem_rdata <= sram[mem_addr];
        iss_cnt++;
      end
    end
    if (rd_val && rd_rdy) begin
      rd_log.push_back(rd_data);
      rd_cyc.push_back(cyc);
      pop_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ma_addr.delete(); ma_we.delete(); ma_data.delete();
    rd_log.delete(); rd_cyc.delete();
    iss_cnt = 0; pop_cnt = 0;
  endtask

  task automatic do_cfg(input cmd_t cmd, input logic dir, output bit ok);
    ok = 1'b0;
    cfg_info = {cmd, dir};
    cfg_val = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (cfg_rdy) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cfg_val = 1'b0;
  endtask

  task automatic wait_done(input logic dir, input bit rnd, output bit ok);
    bit hs;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (dir) rd_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else begin
        wr_val  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_data = wpat;
      end
      hs = !dir && wr_val && wr_rdy;
      tick();
      if (hs) wpat = wpat + 1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    rd_rdy = 1'b0;
    wr_val = 1'b0;
  endtask

  task automatic run_xfer(input cmd_t cmd, input logic dir, input bit rnd, input string nm);
    bit ok;
    do_cfg(cmd, dir, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_cfg timeout waiting for cfg_rdy", nm); return; end
    wait_done(dir, rnd, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done timeout waiting for done", nm); end
    tick();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cfg_rdy, rd_val, wr_rdy, mem_en, mem_we, busy, done} !== 7'd0 || cur_cmd !== '0 ||
        mem_addr !== '0 || rd_data !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ctl=%b cmd=%0h addr=%0h exp all zero",
               {cfg_rdy, rd_val, wr_rdy, mem_en, mem_we, busy, done}, cur_cmd, mem_addr);
    end
    #11 rst_n = 1'b1;
    tick();
    checks++;
    if (cfg_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_cfg_rdy got rdy=%b busy=%b exp rdy=1 busy=0", cfg_rdy, busy);
    end
  endtask

  task automatic test_read_basic();
    bit ok;
    thr = 4'd0; clear_logs(); rd_rdy = 1'b1;
    do_cfg(3'd4, DIR_RD, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_basic_cfg timeout"); end
    tick();
    checks++;
    if (rd_val !== 1'b0) begin errors++; $display("FAIL rd_lat_early got rd_val=%b exp 0", rd_val); end
    tick();
    checks++;
    if (rd_val !== 1'b1 || rd_data !== DATA_W'(32'h100)) begin
      errors++; $display("FAIL rd_lat got rd_val=%b data=%0h exp 1 / 100", rd_val, rd_data);
    end
    wait_done(DIR_RD, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_basic_done timeout"); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cur_cmd !== 3'd4) begin
      errors++; $display("FAIL rd_done_pulse got done=%b busy=%b cmd=%0d exp 0 0 4", done, busy, cur_cmd);
    end
    checks++;
    if (rd_log.size() != 8 || ma_addr.size() != 8) begin
      errors++; $display("FAIL rd_basic_count got beats=%0d issues=%0d exp 8 8", rd_log.size(), ma_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rd_log[i] !== DATA_W'(32'h100 + i) || ma_addr[i] !== ADDR_W'(32'h100 + i) ||
            ma_we[i] !== 1'b0 || rd_cyc[i] != rd_cyc[0] + i) begin
          errors++;
          $display("FAIL rd_basic_beat%0d got data=%0h addr=%0h cyc=%0d exp %0h cyc=%0d",
                   i, rd_log[i], ma_addr[i], rd_cyc[i], 32'h100 + i, rd_cyc[0] + i);
        end
      end
    end
    clear_logs();
    run_xfer(3'd4, DIR_RD, 1'b0, "rd_repeat");
    checks++;
    if (ma_addr.size() == 0 || ma_addr[0] !== 12'h108 || rd_log.size() == 0 || rd_log[0] !== DATA_W'(32'h108)) begin
      errors++; $display("FAIL rd_ptr_persist exp first addr/data 108 (issues=%0d)", ma_addr.size());
    end
  endtask

  task automatic test_write();
    thr = 4'd8; clear_logs(); wpat = DATA_W'(32'hC0DE0000);
    run_xfer(3'd1, DIR_WR, 1'b1, "wr");
    checks++;
    if (ma_addr.size() != 64) begin
      errors++; $display("FAIL wr_count got %0d exp 64", ma_addr.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (ma_we[i] !== 1'b1 || ma_addr[i] !== ADDR_W'(32'h200 + i) ||
            ma_data[i] !== DATA_W'(32'hC0DE0000 + i)) begin
          errors++;
          $display("FAIL wr_beat%0d got we=%b addr=%0h data=%0h exp 1 %0h %0h",
                   i, ma_we[i], ma_addr[i], ma_data[i], 32'h200 + i, 32'hC0DE0000 + i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a;
    thr = 4'd0; clear_logs();
    run_xfer(3'd2, DIR_RD, 1'b0, "wrap");
    checks++;
    if (ma_addr.size() != 10 || rd_log.size() != 10) begin
      errors++; $display("FAIL wrap_count got issues=%0d beats=%0d exp 10", ma_addr.size(), rd_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp_a = ADDR_W'(32'h10 + (i % 4));
        checks++;
        if (ma_addr[i] !== exp_a || rd_log[i] !== DATA_W'(exp_a)) begin
          errors++; $display("FAIL wrap_beat%0d got addr=%0h data=%0h exp %0h", i, ma_addr[i], rd_log[i], exp_a);
        end
      end
    end
  endtask

  task automatic test_rd_stall();
    bit ok, seen, pv, pr;
    logic [DATA_W-1:0] pd;
    thr = 4'd15; clear_logs(); seen = 1'b0;
    do_cfg(3'd5, DIR_RD, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_cfg timeout"); end
    for (int i = 0; i < 6000 && ok && !seen; i++) begin
      pv = rd_val; pd = rd_data;
      rd_rdy = 1'($urandom_range(0, 1)); pr = rd_rdy;
      tick();
      if (pv && !pr) begin
        checks++;
        if (rd_val !== 1'b1 || rd_data !== pd) begin
          errors++; $display("FAIL stall_hold got val=%b data=%0h exp 1 %0h", rd_val, rd_data, pd);
        end
      end
      checks++;
      if (iss_cnt - pop_cnt > 2) begin
        errors++; $display("FAIL stall_prefetch got ahead=%0d exp <=2", iss_cnt - pop_cnt);
      end
      if (done) seen = 1'b1;
    end
    rd_rdy = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_done timeout"); end
    tick();
    checks++;
    if (rd_log.size() != 16) begin
      errors++; $display("FAIL stall_count got %0d exp 16", rd_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rd_log[i] !== DATA_W'(32'h300 + i)) begin
          errors++; $display("FAIL stall_beat%0d got %0h exp %0h", i, rd_log[i], 32'h300 + i);
        end
      end
    end
  endtask

  task automatic test_ptr_clr();
    bit ok;
    thr = 4'd0;
    clear_logs();
    run_xfer(3'd3, DIR_RD, 1'b0, "clr1");
    checks++;
    if (ma_addr.size() == 0 || ma_addr[0] !== 12'h040) begin errors++; $display("FAIL clr_first exp start 40"); end
    clear_logs();
    do_cfg(3'd3, DIR_RD, ok);
    ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
    wait_done(DIR_RD, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clr_trans_done timeout"); end
    tick();
    checks++;
    if (ma_addr.size() != 4) begin
      errors++; $display("FAIL clr_trans_count got %0d exp 4", ma_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ma_addr[i] !== ADDR_W'(32'h44 + i)) begin
          errors++; $display("FAIL clr_trans_addr%0d got %0h exp %0h", i, ma_addr[i], 32'h44 + i);
        end
      end
    end
    ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
    clear_logs();
    run_xfer(3'd3, DIR_RD, 1'b0, "clr3");
    checks++;
    if (ma_addr.size() == 0 || ma_addr[0] !== 12'h040) begin errors++; $display("FAIL clr_idle exp start 40"); end
    clear_logs();
    ptr_clr = 1'b1;
    do_cfg(3'd3, DIR_RD, ok);
    ptr_clr = 1'b0;
    wait_done(DIR_RD, 1'b0, ok);
    tick();
    checks++;
    if (ma_addr.size() == 0 || ma_addr[0] !== 12'h040) begin errors++; $display("FAIL clr_with_cfg exp start 40"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    thr = 4'd0; clear_logs(); rd_rdy = 1'b1;
    do_cfg(3'd6, DIR_RD, ok);
    for (int i = 0; i < 100 && rd_log.size() < 5; i++) tick();
    checks++;
    if (rd_log.size() != 5 || rd_log[4] !== DATA_W'(32'h384) || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got beats=%0d busy=%b exp 5 beats busy=1", rd_log.size(), busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_rdy, rd_val, wr_rdy, mem_en, mem_we, busy, done} !== 7'd0 || cur_cmd !== '0 ||
        mem_addr !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ctl=%b cmd=%0h data=%0h exp all zero",
               {cfg_rdy, rd_val, wr_rdy, mem_en, mem_we, busy, done}, cur_cmd, rd_data);
    end
    rd_rdy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    run_xfer(3'd6, DIR_RD, 1'b0, "rst_restart");
    checks++;
    if (rd_log.size() != 64 || ma_addr[0] !== 12'h380 || rd_log[0] !== DATA_W'(32'h380) ||
        rd_log[1] !== DATA_W'(32'h381)) begin
      errors++; $display("FAIL rst_restart got beats=%0d exp 64 starting at 380", rd_log.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = DATA_W'(i);
    for (int k = 0; k < NUM_CMD; k++) begin
      t_len[k] = '0; t_base[k] = '0; t_size[k] = 12'd1;
    end
    t_len[1] = 10'd63; t_base[1] = 12'h200; t_size[1] = 12'h100;
    t_len[2] = 10'd9;  t_base[2] = 12'h010; t_size[2] = 12'h004;
    t_len[3] = 10'd3;  t_base[3] = 12'h040; t_size[3] = 12'h020;
    t_len[4] = 10'd7;  t_base[4] = 12'h100; t_size[4] = 12'h100;
    t_len[5] = 10'd15; t_base[5] = 12'h300; t_size[5] = 12'h040;
    t_len[6] = 10'd63; t_base[6] = 12'h380; t_size[6] = 12'h080;
    test_reset();
    test_read_basic();
    test_write();
    test_wrap();
    test_rd_stall();
    test_ptr_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
